// File: rtl/multicycle_controller.sv
// multicycle_controller -- multi-cycle main control FSM for the RV32I datapath.
//
// Each instruction is sequenced through FETCH/DECODE/EXEC/(MEM)/WB. Memory
// accesses use a req/ready handshake. The opcode is latched when FETCH
// completes. Datapath enables are decoded from the registered state and the
// latched opcode. The handshake-completion strobes (ir_load, pc_write, and the
// STORE retire pulse in MEM) are additionally qualified by mem_ready.
//
// Optional feature: define ILLEGAL_TRAP_EN to add a TRAP state and a `trap`
// output. With it, an illegal opcode or a memory timeout parks the FSM in TRAP
// until reset. Without it, illegal opcodes retire as NOPs and memory waits are
// unbounded.
//
// Ports:
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   opcode[6:0]    instr[6:0] from memory, sampled when FETCH completes
//   mem_ready      memory completes the current request this cycle
//   mem_req/mem_we memory request / request is a store
//   ir_load, pc_write, branch, alu_src, mem_to_reg, reg_write  datapath enables
//   alu_op         00 add, 01 branch compare, 10 R funct, 11 I funct
//   busy           low only in IDLE (and TRAP)
//   instr_retired  one-cycle pulse when an instruction completes
//   trap           (ILLEGAL_TRAP_EN only) high while parked in TRAP
module multicycle_controller #(
    parameter int ALUOP_W     = 2,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [6:0]         opcode,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               mem_we,
    output logic               ir_load,
    output logic               pc_write,
    output logic               branch,
    output logic               alu_src,
    output logic               mem_to_reg,
    output logic               reg_write,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               busy,
    output logic               instr_retired
`ifdef ILLEGAL_TRAP_EN
    ,
    output logic               trap
`endif
);

    // Reject configurations that the counter or alu_op cannot represent.
    if (ALUOP_W < 2) begin : g_bad_aluop
        $error("ALUOP_W must be >= 2");
    end
    if (MEM_TIMEOUT < 2 || MEM_TIMEOUT > (1 << CNT_W)) begin : g_bad_tmo
        $error("MEM_TIMEOUT must be >= 2 and fit in CNT_W bits");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
    } state_t;

    state_t     state, nxt;
    logic [6:0] opc_q;
    logic [1:0] op2;

    logic is_r, is_i, is_ld, is_st, is_sb, legal;
    assign is_r  = (opc_q == 7'b0110011);
    assign is_i  = (opc_q == 7'b0010011);
    assign is_ld = (opc_q == 7'b0000011);
    assign is_st = (opc_q == 7'b0100011);
    assign is_sb = (opc_q == 7'b1100011);
    assign legal = is_r | is_i | is_ld | is_st | is_sb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                             opc_q <= '0;
        else if (state == S_FETCH && mem_ready) opc_q <= opcode;
    end

`ifdef ILLEGAL_TRAP_EN
    // The wait counter only exists to detect timeouts. Without the trap
    // feature it would have no consumer.
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(MEM_TIMEOUT - 1);
    logic [CNT_W-1:0] cnt;
    logic             req_state, timeout;

    assign req_state = (state == S_FETCH) || (state == S_MEM);
    // The counter value is 0 in the first request cycle. Reaching
    // MEM_TIMEOUT-1 with no mem_ready is the timeout. mem_ready takes
    // priority over a timeout in the same cycle.
    assign timeout   = req_state && !mem_ready && (cnt == TMO_LAST);

    // FETCH/MEM are only entered from non-request states, or through a
    // completed handshake. Clearing outside those cycles therefore gives a
    // zero count on entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                      cnt <= '0;
        else if (!req_state || mem_ready) cnt <= '0;
        else if (cnt != TMO_LAST)        cnt <= cnt + 1'b1;
    end
`endif

    always_comb begin
        nxt           = state;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        ir_load       = 1'b0;
        pc_write      = 1'b0;
        branch        = 1'b0;
        alu_src       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        op2           = 2'b00;
        busy          = 1'b0;
        instr_retired = 1'b0;
`ifdef ILLEGAL_TRAP_EN
        trap          = 1'b0;
`endif
        case (state)
            S_IDLE: nxt = S_FETCH;
            S_FETCH: begin
                busy    = 1'b1;
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_load  = 1'b1;
                    pc_write = 1'b1;
                    nxt      = S_DECODE;
                end
`ifdef ILLEGAL_TRAP_EN
                else if (timeout) nxt = S_TRAP;
`endif
            end
            S_DECODE: begin
                busy = 1'b1;
                if (legal) nxt = S_EXEC;
                else begin
`ifdef ILLEGAL_TRAP_EN
                    nxt = S_TRAP;
`else
                    instr_retired = 1'b1;   // illegal opcode retires as NOP
                    nxt           = S_FETCH;
`endif
                end
            end
            S_EXEC: begin
                busy = 1'b1;
                if (is_r) begin
                    op2 = 2'b10;
                    nxt = S_WB;
                end else if (is_i) begin
                    op2     = 2'b11;
                    alu_src = 1'b1;
                    nxt     = S_WB;
                end else if (is_ld || is_st) begin
                    op2     = 2'b00;
                    alu_src = 1'b1;
                    nxt     = S_MEM;
                end else begin                     // SB: only legal class left
                    op2           = 2'b01;
                    branch        = 1'b1;
                    instr_retired = 1'b1;
                    nxt           = S_FETCH;
                end
            end
            S_MEM: begin
                busy    = 1'b1;
                mem_req = 1'b1;
                mem_we  = is_st;
                if (mem_ready) begin
                    if (is_st) begin
                        instr_retired = 1'b1;
                        nxt           = S_FETCH;
                    end else begin
                        nxt = S_WB;
                    end
                end
`ifdef ILLEGAL_TRAP_EN
                else if (timeout) nxt = S_TRAP;
`endif
            end
            S_WB: begin
                busy          = 1'b1;
                reg_write     = 1'b1;
                mem_to_reg    = is_ld;
                instr_retired = 1'b1;
                nxt           = S_FETCH;
            end
`ifdef ILLEGAL_TRAP_EN
            S_TRAP: trap = 1'b1;                   // sticky until reset
`endif
            default: nxt = S_IDLE;
        endcase
    end

    assign alu_op = ALUOP_W'(op2);

endmodule

// File: tb/tb_multicycle_controller.sv
// Testbench for multicycle_controller.
// Each instruction is expanded into its per-cycle schedule of expected
// outputs, which the class rules define. A single negedge process compares
// the DUT against that queue. Literal latency checks pin the schedules.
module tb_multicycle_controller;
    localparam int TMO = 16;
    localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011,
                           OP_ST = 7'b0100011, OP_SB = 7'b1100011, OP_BAD = 7'b1111111;

    logic clk = 1'b0, rst_n = 1'b0, mem_ready = 1'b0;
    logic [6:0] opcode = '0;
    logic mem_req, mem_we, ir_load, pc_write, branch, alu_src, mem_to_reg, reg_write;
    logic [1:0] alu_op;
    logic busy, instr_retired, trap_w;

    typedef struct packed {
        logic trap, mem_req, mem_we, ir_load, pc_write, branch, alu_src, mem_to_reg, reg_write;
        logic [1:0] alu_op;
        logic busy, retired;
    } exp_t;

    exp_t q[$];
    exp_t dut_v, ce;
    int total = 0, bad = 0, lat = 0, last_lat = 0;
    bit trapped = 0;

    multicycle_controller dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .ir_load(ir_load), .pc_write(pc_write),
        .branch(branch), .alu_src(alu_src), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .alu_op(alu_op), .busy(busy), .instr_retired(instr_retired)
`ifdef ILLEGAL_TRAP_EN
        , .trap(trap_w)
`endif
    );
`ifndef ILLEGAL_TRAP_EN
    assign trap_w = 1'b0;
`endif

    assign dut_v = {trap_w, mem_req, mem_we, ir_load, pc_write, branch, alu_src,
                    mem_to_reg, reg_write, alu_op, busy, instr_retired};

    always #5 clk = ~clk;

    // Compare process: one expected vector per cycle while the queue holds one.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            ce = q.pop_front();
            total++;
            if (dut_v !== ce) begin
                bad++;
                $display("FAIL cycle_outputs t=%0t got=%b exp=%b", $time, dut_v, ce);
            end
        end
    end

    // Latency monitor: busy cycles up to and including the retire pulse.
    always @(negedge clk) begin
        if (!rst_n) lat = 0;
        else begin
            if (busy) lat++;
            if (instr_retired) begin
                last_lat = lat;
                lat = 0;
            end
        end
    end

    task automatic chk(input string nm, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
        end
    endtask

    task automatic pin_lat(input string nm, input int exp);
        @(negedge clk); #1;
        chk(nm, last_lat, exp);
    endtask

    function automatic int cls_of(input logic [6:0] o);
        case (o)
            OP_R: return 0;
            OP_I: return 1;
            OP_LD: return 2;
            OP_ST: return 3;
            OP_SB: return 4;
            default: return 5;
        endcase
    endfunction

    task automatic cyc(input logic [6:0] op, input logic rdy, input exp_t e);
        @(posedge clk); #1;
        opcode = op;
        mem_ready = rdy;
        q.push_back(e);
    endtask

    task automatic do_reset(input int n);
        exp_t z = '0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            rst_n = 1'b0;
            mem_ready = 1'($urandom);
            opcode = 7'($urandom);
            q.push_back(z);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        mem_ready = 1'($urandom);    // IDLE ignores it
        q.push_back(z);
        trapped = 0;
    endtask

    task automatic trap_run();
        exp_t e = '0;
        e.trap = 1'b1;
        for (int i = 0; i < 3; i++) cyc(7'($urandom), 1'($urandom), e);
        trapped = 1;
    endtask

    // fw/mw: cycles without mem_ready before the completing cycle in FETCH/MEM.
    task automatic do_instr(input logic [6:0] opc, input int fw, input int mw);
        exp_t e;
        int c = cls_of(opc);
        for (int i = 0; i < fw; i++) begin
`ifdef ILLEGAL_TRAP_EN
            if (i == TMO) begin trap_run(); return; end
`endif
            e = '0; e.mem_req = 1; e.busy = 1;
            cyc(7'($urandom), 1'b0, e);
        end
        e = '0; e.mem_req = 1; e.busy = 1; e.ir_load = 1; e.pc_write = 1;
        cyc(opc, 1'b1, e);
        e = '0; e.busy = 1;
`ifndef ILLEGAL_TRAP_EN
        if (c == 5) e.retired = 1;
`endif
        cyc(7'($urandom), 1'($urandom), e);
        if (c == 5) begin
`ifdef ILLEGAL_TRAP_EN
            trap_run();
`endif
            return;
        end
        e = '0; e.busy = 1;
        case (c)
            0: e.alu_op = 2'b10;
            1: begin e.alu_op = 2'b11; e.alu_src = 1; end
            2, 3: begin e.alu_op = 2'b00; e.alu_src = 1; end
            default: begin e.alu_op = 2'b01; e.branch = 1; e.retired = 1; end
        endcase
        cyc(7'($urandom), 1'($urandom), e);
        if (c == 4) return;
        if (c == 2 || c == 3) begin
            for (int i = 0; i < mw; i++) begin
`ifdef ILLEGAL_TRAP_EN
                if (i == TMO) begin trap_run(); return; end
`endif
                e = '0; e.mem_req = 1; e.busy = 1; e.mem_we = (c == 3);
                cyc(7'($urandom), 1'b0, e);
            end
            e = '0; e.mem_req = 1; e.busy = 1; e.mem_we = (c == 3); e.retired = (c == 3);
            cyc(7'($urandom), 1'b1, e);
            if (c == 3) return;
        end
        e = '0; e.busy = 1; e.reg_write = 1; e.mem_to_reg = (c == 2); e.retired = 1;
        cyc(7'($urandom), 1'($urandom), e);
    endtask

    initial begin
        logic [6:0] tbl[5];
        logic [6:0] opc;
        int fw, mw;
        exp_t e;
        tbl = '{OP_R, OP_I, OP_LD, OP_ST, OP_SB};

        do_reset(3);
        chk("idle_mem_req", int'(mem_req), 0);

        // Directed schedules, with literal latencies.
        do_instr(OP_R, 0, 0);   pin_lat("lat_r", 4);
        do_instr(OP_LD, 0, 3);  pin_lat("lat_ld_wait3", 8);
        do_instr(OP_LD, 0, 0);  pin_lat("lat_ld", 5);
        do_instr(OP_ST, 0, 0);  pin_lat("lat_st", 4);
        do_instr(OP_SB, 0, 0);  pin_lat("lat_sb", 3);
        do_instr(OP_I, 1, 0);   pin_lat("lat_i_fwait1", 5);
        do_instr(OP_R, TMO - 1, 0); pin_lat("lat_ready_at_limit", 4 + TMO - 1);
`ifdef ILLEGAL_TRAP_EN
        do_instr(OP_BAD, 0, 0);
        @(negedge clk); #1; chk("trap_illegal", int'(trap_w), 1);
        do_reset(3);
        do_instr(OP_R, TMO + 4, 0);
        @(negedge clk); #1; chk("trap_timeout", int'(trap_w), 1);
        do_reset(3);
`else
        do_instr(OP_BAD, 0, 0); pin_lat("lat_nop", 2);
        do_instr(OP_LD, 0, 25); pin_lat("lat_ld_long_wait", 30);
`endif

        // Reset while a LOAD is waiting in MEM.
        e = '0; e.mem_req = 1; e.busy = 1; e.ir_load = 1; e.pc_write = 1;
        cyc(OP_LD, 1'b1, e);
        e = '0; e.busy = 1; cyc(7'($urandom), 1'b0, e);
        e = '0; e.busy = 1; e.alu_src = 1; cyc(7'($urandom), 1'b0, e);
        e = '0; e.busy = 1; e.mem_req = 1; cyc(7'($urandom), 1'b0, e);
        @(posedge clk); #1;
        mem_ready = 1'b0;
        #1 chk("mem_req_before_reset", int'(mem_req), 1);
        rst_n = 1'b0;
        #1 chk("mem_req_async_drop", int'(mem_req), 0);
        chk("busy_async_drop", int'(busy), 0);
        do_reset(2);
        do_instr(OP_R, 0, 0);   pin_lat("lat_after_reset", 4);

        // Randomized instruction stream.
        for (int n = 0; n < 80; n++) begin
            if (trapped) do_reset(2);
            opc = ($urandom_range(0, 5) == 0) ? 7'($urandom) : tbl[$urandom_range(0, 4)];
            fw = ($urandom_range(0, 9) == 0) ? int'($urandom_range(10, TMO + 3)) : int'($urandom_range(0, 3));
            mw = ($urandom_range(0, 9) == 0) ? int'($urandom_range(10, TMO + 3)) : int'($urandom_range(0, 3));
            do_instr(opc, fw, mw);
        end

        @(negedge clk); #1;
        chk("queue_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
